// File: rtl/pulse_monitor_pkg.sv
// Purpose : shared state encoding, default parameters and window helpers for the pulse period monitor.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package pulse_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    TRACK      = 2'd2
  } mon_state_t;

  localparam int DEF_WIDTH      = 24;
  localparam int DEF_EXPECTED   = 30;
  localparam int DEF_TOL        = 2;
  localparam int DEF_LOCK_COUNT = 3;

  // Lower window edge; a tolerance as large as the nominal period would give
  // zero or a negative bound, so the window floor is pinned at one cycle.
  function automatic int calc_min_p(input int expected, input int tol);
    if (tol >= expected) begin
      return 1;
    end
    return expected - tol;
  endfunction

  // Bits needed to hold a run count of 0..lock_count (never less than one).
  function automatic int calc_run_w(input int lock_count);
    int w;
    w = $clog2(lock_count + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pulse_period_monitor_if.sv
// Purpose : bundles the monitor's control inputs and measurement outputs.
// Latency : n/a (wiring only); slave side drives registered outputs.
// Backpr. : none; pulse_in is a free-running tick, outputs are strobes/levels.
// Ports   : enable, pulse_in (master -> slave); period, period_valid, early,
//           timeout, locked (slave -> master).
interface pulse_period_monitor_if
  import pulse_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             enable;
  logic             pulse_in;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             early;
  logic             timeout;
  logic             locked;

  modport master (
    output enable,
    output pulse_in,
    input  period,
    input  period_valid,
    input  early,
    input  timeout,
    input  locked
  );

  modport slave (
    input  enable,
    input  pulse_in,
    output period,
    output period_valid,
    output early,
    output timeout,
    output locked
  );

endinterface

// File: rtl/period_window_cmp.sv
// Purpose : turns the running cycle counter into the period a pulse now would measure, and compares it to the window.
// Latency : purely combinational; the parent registers everything derived from it.
// Backpr. : none.
// Ports   : counter, min_p, max_p in; elapsed, below_min, at_max out.
module period_window_cmp
  import pulse_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] min_p,
  input  logic [WIDTH-1:0] max_p,
  output logic [WIDTH-1:0] elapsed,
  output logic             below_min,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // Saturate instead of wrapping; the parent feeds elapsed straight back in
  // as the next counter value, so this is also the counter saturation.
  assign elapsed   = (counter == ALL_ONES) ? ALL_ONES : (counter + ONE);
  assign below_min = (elapsed < min_p);
  // >= rather than == so a saturated counter still terminates the wait.
  assign at_max    = (elapsed >= max_p);

endmodule

// File: rtl/pulse_period_monitor.sv
// Purpose : measures the cycle gap between pulse_in ticks, flags early/missing pulses and reports lock.
// Latency : one cycle from the terminating pulse_in (or the expiring cycle) to period_valid/early/timeout.
// Backpr. : none; every output is a registered strobe or level, no handshake.
// Ports   : clk, rst (async active-low); mon (slave modport: enable, pulse_in in;
//           period, period_valid, early, timeout, locked out).
module pulse_period_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EXPECTED   = DEF_EXPECTED,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic                    clk,
  input  logic                    rst,
  pulse_period_monitor_if.slave   mon
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(calc_min_p(EXPECTED, TOL));
  localparam logic [WIDTH-1:0] MAX_P = WIDTH'(EXPECTED + TOL);

  localparam int               RUN_W  = calc_run_w(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_LK = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_1  = RUN_W'(1);

  mon_state_t       state;
  logic [WIDTH-1:0] counter;
  logic [RUN_W-1:0] run_cnt;

  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             early_q;
  logic             timeout_q;
  logic             locked_q;

  logic [WIDTH-1:0] elapsed;
  logic             below_min;
  logic             at_max;
  logic [RUN_W-1:0] run_next;

  period_window_cmp #(
    .WIDTH (WIDTH)
  ) u_window_cmp (
    .counter   (counter),
    .min_p     (MIN_P),
    .max_p     (MAX_P),
    .elapsed   (elapsed),
    .below_min (below_min),
    .at_max    (at_max)
  );

  // Run count after one more in-window period; holds once lock is reached.
  assign run_next = (run_cnt >= RUN_LK) ? RUN_LK : (run_cnt + RUN_1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      counter        <= '0;
      run_cnt        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      early_q        <= 1'b0;
      timeout_q      <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      // Strobes live for exactly one cycle unless re-raised below.
      period_valid_q <= 1'b0;
      early_q        <= 1'b0;
      timeout_q      <= 1'b0;

      if (!mon.enable) begin
        // Disable wins over everything; the last period is kept for software.
        state    <= IDLE;
        counter  <= '0;
        run_cnt  <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter <= '0;
            state   <= WAIT_FIRST;
          end

          WAIT_FIRST: begin
            // First pulse only opens the measurement; nothing to report yet.
            counter <= '0;
            if (mon.pulse_in) begin
              state <= TRACK;
            end
          end

          TRACK: begin
            if (mon.pulse_in) begin
              // A pulse on the last allowed cycle is checked before the
              // timeout branch, so it is measured as in-window.
              period_q       <= elapsed;
              period_valid_q <= 1'b1;
              counter        <= '0;
              if (below_min) begin
                early_q  <= 1'b1;
                run_cnt  <= '0;
                locked_q <= 1'b0;
              end else begin
                run_cnt  <= run_next;
                locked_q <= (run_next == RUN_LK);
              end
            end else if (at_max) begin
              // Missing pulse: report it and restart from a fresh first pulse.
              timeout_q <= 1'b1;
              state     <= WAIT_FIRST;
              counter   <= '0;
              run_cnt   <= '0;
              locked_q  <= 1'b0;
            end else begin
              counter <= elapsed;
            end
          end

          default: begin
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

  assign mon.period       = period_q;
  assign mon.period_valid = period_valid_q;
  assign mon.early        = early_q;
  assign mon.timeout      = timeout_q;
  assign mon.locked       = locked_q;

endmodule
